// File: rtl/alu_issue_stage.sv
// Execute-stage input register ahead of the ALU: valid/ready intake, operand B select,
// writeback forwarding on capture and while held, and a 2-entry skid buffer.
module alu_issue_stage #(
    parameter int unsigned dataWidth    = 32,
    parameter int unsigned selectWidth  = 4,
    parameter int unsigned regAddrWidth = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,

    input  logic                    inValid,
    output logic                    inReady,
    input  logic [dataWidth-1:0]    rs1Data,
    input  logic [dataWidth-1:0]    rs2Data,
    input  logic [regAddrWidth-1:0] rs1Addr,
    input  logic [regAddrWidth-1:0] rs2Addr,
    input  logic [regAddrWidth-1:0] rdAddrIn,
    input  logic [dataWidth-1:0]    immediate,
    input  logic                    useImm,
    input  logic [selectWidth-1:0]  ALUSelectIn,

    input  logic                    fwdValid,
    input  logic [regAddrWidth-1:0] fwdAddr,
    input  logic [dataWidth-1:0]    fwdData,

    output logic                    outValid,
    input  logic                    outReady,
    output logic [dataWidth-1:0]    inputA,
    output logic [dataWidth-1:0]    inputB,
    output logic [selectWidth-1:0]  ALUSelect,
    output logic [regAddrWidth-1:0] rdAddrOut
);

    typedef struct packed {
        logic [dataWidth-1:0]    op_a;
        logic [dataWidth-1:0]    op_b;
        logic [regAddrWidth-1:0] rs1;
        logic [regAddrWidth-1:0] rs2;
        logic                    use_imm;
        logic [selectWidth-1:0]  sel;
        logic [regAddrWidth-1:0] rd;
    } entry_t;

    // Overwrite register-sourced operands that writeback is updating this cycle.
    function automatic entry_t snoop_entry(
        input entry_t                    e,
        input logic                      fv,
        input logic [regAddrWidth-1:0]   fa,
        input logic [dataWidth-1:0]      fd
    );
        entry_t r;
        logic   hit;
        r   = e;
        hit = fv && (fa != '0);
        if (hit && (e.rs1 == fa)) begin
            r.op_a = fd;
        end
        if (hit && !e.use_imm && (e.rs2 == fa)) begin
            r.op_b = fd;
        end
        return r;
    endfunction

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t new_entry;
    entry_t main_snp;
    entry_t skid_snp;
    logic   accept;
    logic   transfer;
    logic   fwd_rs1;
    logic   fwd_rs2;

    assign accept   = inValid && in_ready_q;
    assign transfer = main_valid_q && outReady;

    // Capture path: x0 never takes a forwarded value.
    always_comb begin
        fwd_rs1 = fwdValid && (fwdAddr == rs1Addr) && (rs1Addr != '0);
        fwd_rs2 = fwdValid && (fwdAddr == rs2Addr) && (rs2Addr != '0);

        new_entry         = '0;
        new_entry.op_a    = fwd_rs1 ? fwdData : rs1Data;
        new_entry.op_b    = useImm ? immediate : (fwd_rs2 ? fwdData : rs2Data);
        new_entry.rs1     = rs1Addr;
        new_entry.rs2     = rs2Addr;
        new_entry.use_imm = useImm;
        new_entry.sel     = ALUSelectIn;
        new_entry.rd      = rdAddrIn;
    end

    always_comb begin
        main_snp     = snoop_entry(main_q, fwdValid, fwdAddr, fwdData);
        skid_snp     = snoop_entry(skid_q, fwdValid, fwdAddr, fwdData);
        main_d       = main_snp;
        skid_d       = skid_snp;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;

        if (!main_valid_q) begin
            if (accept) begin
                main_valid_d = 1'b1;
                main_d       = new_entry;
            end
        end else if (transfer) begin
            // A full skid implies inReady was low, so no accept can collide here.
            if (skid_valid_q) begin
                main_d       = skid_snp;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = new_entry;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign inReady   = in_ready_q;
    assign outValid  = main_valid_q;
    assign inputA    = main_q.op_a;
    assign inputB    = main_q.op_b;
    assign ALUSelect = main_q.sel;
    assign rdAddrOut = main_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and reference-queue checks for alu_issue_stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] rs1Data;
    logic [31:0] rs2Data;
    logic [4:0]  rs1Addr;
    logic [4:0]  rs2Addr;
    logic [4:0]  rdAddrIn;
    logic [31:0] immediate;
    logic        useImm;
    logic [3:0]  ALUSelectIn;
    logic        fwdValid;
    logic [4:0]  fwdAddr;
    logic [31:0] fwdData;
    logic        outValid;
    logic        outReady;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [3:0]  ALUSelect;
    logic [4:0]  rdAddrOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        imm;
        logic [3:0]  sel;
        logic [4:0]  rd;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    alu_issue_stage #(
        .dataWidth   (32),
        .selectWidth (4),
        .regAddrWidth(5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .rs1Data    (rs1Data),
        .rs2Data    (rs2Data),
        .rs1Addr    (rs1Addr),
        .rs2Addr    (rs2Addr),
        .rdAddrIn   (rdAddrIn),
        .immediate  (immediate),
        .useImm     (useImm),
        .ALUSelectIn(ALUSelectIn),
        .fwdValid   (fwdValid),
        .fwdAddr    (fwdAddr),
        .fwdData    (fwdData),
        .outValid   (outValid),
        .outReady   (outReady),
        .inputA     (inputA),
        .inputB     (inputB),
        .ALUSelect  (ALUSelect),
        .rdAddrOut  (rdAddrOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] a1,
                          input logic [4:0] a2, input logic [4:0] rd, input logic [3:0] sel,
                          input logic [31:0] imm, input logic ui);
        rs1Data     = d1;
        rs2Data     = d2;
        rs1Addr     = a1;
        rs2Addr     = a2;
        rdAddrIn    = rd;
        ALUSelectIn = sel;
        immediate   = imm;
        useImm      = ui;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 01", {outValid, inReady});
        end
        checks++;
        if ({inputA, inputB, ALUSelect, rdAddrOut} !== 73'd0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 0", {inputA, inputB, ALUSelect, rdAddrOut});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_op(32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'd0, 32'd0, 1'b0);
        inValid  = 1'b1;
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
        checks++;
        if ({outValid, inputA, inputB, ALUSelect, rdAddrOut} !== {1'b1, 32'd5, 32'd7, 4'd0, 5'd3})
        begin
            errors++;
            $display("FAIL single_out: got v=%b a=%0d b=%0d s=%0d rd=%0d, want 1 5 7 0 3",
                     outValid, inputA, inputB, ALUSelect, rdAddrOut);
        end
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: outValid=%b, want 0", outValid);
        end
    endtask

    task automatic test_imm_fwd();
        set_op(32'h1234_5678, 32'd0, 5'd2, 5'd6, 5'd4, 4'd5, 32'hFFFF_FFFC, 1'b1);
        fwdValid = 1'b1;
        fwdAddr  = 5'd2;
        fwdData  = 32'hDEAD_BEEF;
        inValid  = 1'b1;
        outReady = 1'b1;
        tick();
        checks++;
        if ({outValid, inputA, inputB, ALUSelect} !== {1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 4'd5})
        begin
            errors++;
            $display("FAIL imm_fwd: got v=%b a=%h b=%h s=%0d, want 1 deadbeef fffffffc 5",
                     outValid, inputA, inputB, ALUSelect);
        end
        rs1Addr = 5'd0;
        fwdAddr = 5'd0;
        rs1Data = 32'h0000_1111;
        tick();
        checks++;
        if ({inputA, inputB} !== {32'h0000_1111, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL x0_no_fwd: got a=%h b=%h, want 00001111 fffffffc", inputA, inputB);
        end
        inValid  = 1'b0;
        fwdValid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        outReady = 1'b0;
        inValid  = 1'b1;
        set_op(32'hA1, 32'hA2, 5'd1, 5'd2, 5'd10, 4'd1, 32'd0, 1'b0);
        tick();
        checks++;
        if ({outValid, inReady, inputA} !== {2'b11, 32'hA1}) begin
            errors++;
            $display("FAIL bp_a_loaded: got v=%b r=%b a=%h, want 1 1 a1", outValid, inReady, inputA);
        end
        set_op(32'hB1, 32'hB2, 5'd1, 5'd2, 5'd11, 4'd2, 32'd0, 1'b0);
        tick();
        checks++;
        if ({outValid, inReady, inputA, rdAddrOut} !== {2'b10, 32'hA1, 5'd10}) begin
            errors++;
            $display("FAIL bp_b_skid: got v=%b r=%b a=%h rd=%0d, want 1 0 a1 10",
                     outValid, inReady, inputA, rdAddrOut);
        end
        set_op(32'hC1, 32'hC2, 5'd1, 5'd2, 5'd12, 4'd3, 32'd0, 1'b0);
        tick();
        checks++;
        if ({outValid, inReady, inputA, inputB, ALUSelect} !== {2'b10, 32'hA1, 32'hA2, 4'd1}) begin
            errors++;
            $display("FAIL bp_c_blocked: got v=%b r=%b a=%h b=%h s=%0d, want 1 0 a1 a2 1",
                     outValid, inReady, inputA, inputB, ALUSelect);
        end
        outReady = 1'b1;
        tick();
        checks++;
        if ({outValid, inReady, inputA, inputB, ALUSelect, rdAddrOut} !==
            {2'b11, 32'hB1, 32'hB2, 4'd2, 5'd11}) begin
            errors++;
            $display("FAIL bp_b_out: got v=%b r=%b a=%h b=%h s=%0d rd=%0d, want 1 1 b1 b2 2 11",
                     outValid, inReady, inputA, inputB, ALUSelect, rdAddrOut);
        end
        tick();
        inValid = 1'b0;
        checks++;
        if ({outValid, inputA, inputB, ALUSelect, rdAddrOut} !== {1'b1, 32'hC1, 32'hC2, 4'd3, 5'd12})
        begin
            errors++;
            $display("FAIL bp_c_out: got v=%b a=%h b=%h s=%0d rd=%0d, want 1 c1 c2 3 12",
                     outValid, inputA, inputB, ALUSelect, rdAddrOut);
        end
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: outValid=%b, want 0 (duplicate op)", outValid);
        end
    endtask

    task automatic test_snoop();
        outReady = 1'b0;
        inValid  = 1'b1;
        set_op(32'd100, 32'd1, 5'd4, 5'd9, 5'd7, 4'd6, 32'd55, 1'b0);
        tick();
        inValid  = 1'b0;
        fwdValid = 1'b1;
        fwdAddr  = 5'd9;
        fwdData  = 32'd42;
        tick();
        fwdValid = 1'b0;
        checks++;
        if ({outValid, inputA, inputB} !== {1'b1, 32'd100, 32'd42}) begin
            errors++;
            $display("FAIL snoop_reg: got v=%b a=%0d b=%0d, want 1 100 42", outValid, inputA, inputB);
        end
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
        inValid  = 1'b1;
        set_op(32'd100, 32'd99, 5'd4, 5'd9, 5'd7, 4'd6, 32'd1, 1'b1);
        tick();
        inValid  = 1'b0;
        fwdValid = 1'b1;
        tick();
        fwdValid = 1'b0;
        checks++;
        if ({outValid, inputA, inputB} !== {1'b1, 32'd100, 32'd1}) begin
            errors++;
            $display("FAIL snoop_imm: got v=%b a=%0d b=%0d, want 1 100 1", outValid, inputA, inputB);
        end
        outReady = 1'b1;
        tick();
    endtask

    task automatic test_flush();
        outReady = 1'b0;
        inValid  = 1'b1;
        set_op(32'd1, 32'd2, 5'd1, 5'd2, 5'd1, 4'd1, 32'd0, 1'b0);
        tick();
        set_op(32'd3, 32'd4, 5'd1, 5'd2, 5'd2, 4'd2, 32'd0, 1'b0);
        tick();
        checks++;
        if ({outValid, inReady} !== 2'b10) begin
            errors++;
            $display("FAIL flush_full: got v=%b r=%b, want 1 0", outValid, inReady);
        end
        flush = 1'b1;
        set_op(32'd5, 32'd6, 5'd1, 5'd2, 5'd3, 4'd3, 32'd0, 1'b0);
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("FAIL flush_clear: got v=%b r=%b, want 0 1", outValid, inReady);
        end
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale: outValid=%b, want 0", outValid);
        end
        inValid = 1'b1;
        tick();
        checks++;
        if ({outValid, inReady} !== 2'b11) begin
            errors++;
            $display("FAIL flush_reload: got v=%b r=%b, want 1 1", outValid, inReady);
        end
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        inValid = 1'b0;
        tick();
        checks++;
        if ({outValid, inReady} !== 2'b01) begin
            errors++;
            $display("FAIL flush_drop_accept: got v=%b r=%b, want 0 1", outValid, inReady);
        end
    endtask

    task automatic test_async_reset();
        outReady = 1'b0;
        inValid  = 1'b1;
        set_op(32'hAAAA, 32'hBBBB, 5'd3, 5'd4, 5'd9, 4'd7, 32'd0, 1'b0);
        tick();
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
        checks++;
        if ({outValid, inReady} !== 2'b10) begin
            errors++;
            $display("FAIL areset_pre: got v=%b r=%b, want 1 0", outValid, inReady);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({outValid, inReady, inputA, inputB, ALUSelect, rdAddrOut} !== {2'b01, 73'd0}) begin
            errors++;
            $display("FAIL areset_now: got v=%b r=%b data=%h, want 0 1 0", outValid, inReady,
                     {inputA, inputB, ALUSelect, rdAddrOut});
        end
        reset    = 1'b1;
        outReady = 1'b1;
        tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: outValid=%b, want 0", outValid);
        end
    endtask

    task automatic test_random_stream();
        int   accepted = 0;
        int   cyc      = 0;
        logic can_acc;
        ent_t e;
        q.delete();
        while (accepted < 1000 && cyc < 20000) begin
            checks++;
            if (outValid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid cyc %0d: outValid=%b, want %0d", cyc, outValid,
                         q.size() != 0);
            end
            checks++;
            if (inReady !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_ready cyc %0d: inReady=%b, want %0d", cyc, inReady, q.size() < 2);
            end
            if (q.size() != 0) begin
                checks++;
                if ({inputA, inputB, ALUSelect, rdAddrOut} !== {q[0].a, q[0].b, q[0].sel, q[0].rd})
                begin
                    errors++;
                    $display("FAIL rnd_data cyc %0d: got a=%h b=%h s=%0d rd=%0d, want %h %h %0d %0d",
                             cyc, inputA, inputB, ALUSelect, rdAddrOut, q[0].a, q[0].b, q[0].sel,
                             q[0].rd);
                end
            end

            inValid     = ($urandom_range(0, 3) != 0);
            outReady    = ($urandom_range(0, 3) != 0);
            rs1Data     = $urandom;
            rs2Data     = $urandom;
            immediate   = $urandom;
            rs1Addr     = 5'($urandom_range(0, 7));
            rs2Addr     = 5'($urandom_range(0, 7));
            rdAddrIn    = 5'($urandom_range(0, 31));
            ALUSelectIn = 4'($urandom_range(0, 15));
            useImm      = ($urandom_range(0, 2) == 0);
            fwdValid    = ($urandom_range(0, 1) == 1);
            fwdAddr     = 5'($urandom_range(0, 7));
            fwdData     = $urandom;

            can_acc = (q.size() < 2);
            if (q.size() != 0 && outReady) begin
                void'(q.pop_front());
            end
            if (inValid && can_acc) begin
                e.rs1 = rs1Addr;
                e.rs2 = rs2Addr;
                e.imm = useImm;
                e.sel = ALUSelectIn;
                e.rd  = rdAddrIn;
                e.a   = rs1Data;
                e.b   = useImm ? immediate : rs2Data;
                q.push_back(e);
                accepted++;
            end
            if (fwdValid && fwdAddr != 5'd0) begin
                foreach (q[i]) begin
                    if (q[i].rs1 == fwdAddr) q[i].a = fwdData;
                    if (!q[i].imm && q[i].rs2 == fwdAddr) q[i].b = fwdData;
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (accepted < 1000) begin
            errors++;
            $display("FAIL rnd_timeout: accepted %0d, want 1000", accepted);
        end
        inValid  = 1'b0;
        fwdValid = 1'b0;
        outReady = 1'b1;
        repeat (3) tick();
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain: outValid=%b, want 0", outValid);
        end
    endtask

    initial begin
        flush    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        fwdValid = 1'b0;
        fwdAddr  = 5'd0;
        fwdData  = 32'd0;
        set_op(32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0, 1'b0);
        test_reset();
        test_single();
        test_imm_fwd();
        test_backpressure();
        test_snoop();
        test_flush();
        test_async_reset();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-stage input register placed directly upstream of the ALU.
- Accepts decoded operations from the decode stage over a valid/ready handshake and selects operand B as either register data or the immediate.
- Applies writeback forwarding and presents registered inputA, inputB and ALUSelect to the ALU.
- A 2-entry skid buffer gives full throughput while keeping inReady a registered signal.

Parameters:
- dataWidth, 32: operand and immediate width.
- selectWidth, 4: ALU operation select width.
- regAddrWidth, 5: register-file address width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous flush; drops all held entries.
- inValid  input  1  decode presents an operation.
- inReady  output  1  stage can accept; registered.
- rs1Data  input  dataWidth  register-file read data for rs1.
- rs2Data  input  dataWidth  register-file read data for rs2.
- rs1Addr  input  regAddrWidth  rs1 index.
- rs2Addr  input  regAddrWidth  rs2 index.
- rdAddrIn  input  regAddrWidth  destination index.
- immediate  input  dataWidth  sign-extended immediate.
- useImm  input  1  operand B comes from immediate, not rs2.
- ALUSelectIn  input  selectWidth  operation code for the ALU.
- fwdValid  input  1  writeback is writing fwdData to fwdAddr this cycle.
- fwdAddr  input  regAddrWidth  writeback destination.
- fwdData  input  dataWidth  writeback value.
- outValid  output  1  inputA, inputB and ALUSelect are valid.
- outReady  input  1  ALU/EX consumer takes the operation this cycle.
- inputA  output  dataWidth  ALU operand A.
- inputB  output  dataWidth  ALU operand B.
- ALUSelect  output  selectWidth  ALU operation select.
- rdAddrOut  output  regAddrWidth  destination index carried with the operation.

Behaviour:
- Reset (reset=0, asynchronous):
  - outValid=0, skid valid=0, inReady=1.
  - inputA, inputB, ALUSelect, rdAddrOut and all skid fields = 0.
- Handshakes:
  - Accept when inValid && inReady.
  - Output transfer when outValid && outReady.
  - inReady = !skidValid, registered.
- Entry contents: opA, opB, rs1Addr, rs2Addr, useImm, ALUSelect, rd.
- Capture forwarding (applies to the accepted input):
  - opA = fwdData if fwdValid && fwdAddr==rs1Addr && rs1Addr!=0; otherwise rs1Data.
  - opB = immediate if useImm. Otherwise, same forwarding rule on rs2, else rs2Data.
  - Register x0 is never forwarded.
- Snoop: every cycle, each held entry whose operand is register-sourced and matches a valid, non-zero fwdAddr has that operand overwritten with fwdData. Immediate operands are never snooped.
- Transitions, evaluated per cycle (M = main/output entry, S = skid):
  - M empty, accept: load M.
  - M full, transfer, S empty, accept: load M with the new entry.
  - M full, transfer, S full: move S to M (with snoop applied), clear S. No accept is possible because inReady=0.
  - M full, no transfer, accept: load S; inReady drops next cycle.
  - M full, transfer, no accept, S empty: M becomes empty.
- Latency and throughput: accepted op appears at the outputs the next cycle; throughput 1 op/cycle sustained under continuous outReady.
- Transfer and snoop in the same cycle: the consumer takes the pre-update register value and the entry leaves. The ALU's own bypass covers this case.
- Output holding: outputs hold stable while outValid && !outReady. Only the snoop may change inputA/inputB during a stall.
- Flush:
  - Clears outValid and skid valid next edge; overrides a same-cycle accept, which is discarded.
  - inReady=1 the cycle after flush.
  - Data fields are don't-care after flush.
- Reset mid-operation: all entries are lost immediately; no partial transfer.
- Field widths: no arithmetic is performed; fields pass through unmodified at full width.

Test Plan:
- Single op: rs1Data=5, rs2Data=7, ALUSelectIn=0, rd=3, inValid pulse, outReady=1 -> next cycle outValid=1, inputA=5, inputB=7, ALUSelect=0, rdAddrOut=3; following cycle outValid=0.
- Immediate plus capture forwarding: rs1Addr=2, fwdValid=1, fwdAddr=2, fwdData=0xDEADBEEF, useImm=1, immediate=0xFFFFFFFC -> inputA=0xDEADBEEF, inputB=0xFFFFFFFC. Repeat with rs1Addr=0, fwdAddr=0 -> inputA=rs1Data.
- Backpressure:
  - Stream ops A, B, C with outReady=0 -> A held on the outputs, B in skid, inReady=0 from the cycle after B is accepted, C not accepted.
  - Raise outReady -> A, B, C emerge in consecutive cycles; no loss or duplication.
- Stall snoop: op held with outReady=0, rs2Addr=9, useImm=0, inputB=1; pulse fwdValid, fwdAddr=9, fwdData=42 -> inputB=42 next cycle; the same pulse with useImm=1 leaves inputB unchanged.
- Flush and reset: M and S full, flush=1 with inValid=1 -> next cycle outValid=0, inReady=1, new op dropped. Drive reset=0 asynchronously mid-stream -> outputs 0 and outValid=0 before the next clock edge.
- Random stream: 1000 random ops with random inValid/outReady/fwd -> output sequence matches a reference queue model with forwarding applied.
